// File: rtl/wavetable_reader.sv
// wavetable_reader
// Fetches one wavetable sample per new NCO address from a synchronous BRAM and
// presents it to the voice mixer through a valid/ready handshake.
//
// Ports:
//   sys_clk       system clock, all logic on the rising edge
//   sys_rst       synchronous reset, active-high
//   nco_addr      current table address from the NCO
//   wave_sel      waveform bank select, sampled at the fetch trigger only
//   mem_addr      BRAM read address {bank, addr}
//   mem_rd_en     BRAM read enable, high for one cycle per fetch
//   mem_rd_data   BRAM read data, valid the cycle after the enabled edge
//   gain          unsigned gain, 128 = unity (WT_GAIN_EN builds only)
//   sample_out    signed sample to the mixer
//   sample_valid  sample_out valid
//   sample_ready  downstream accepts when valid & ready at a rising edge
//   overrun_cnt   saturating count of address changes seen while busy
//
// Build option:
//   WT_GAIN_EN    adds a SCALE state applying the per-voice gain with
//                 saturation; fetch-to-valid latency grows from 3 to 4 edges.

module wavetable_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned S_W    = 16,
  parameter int unsigned BANK_W = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [ADDR_W-1:0]        nco_addr,
  input  logic [BANK_W-1:0]        wave_sel,
  output logic [BANK_W+ADDR_W-1:0] mem_addr,
  output logic                     mem_rd_en,
  input  logic [S_W-1:0]           mem_rd_data,
  input  logic [7:0]               gain,
  output logic [S_W-1:0]           sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [7:0]               overrun_cnt
);

  localparam int unsigned MA_W   = BANK_W + ADDR_W;
  localparam int unsigned PROD_W = S_W + 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SCALE,
    ST_PRESENT
  } state_t;

  state_t            r_state;
  logic [MA_W-1:0]   r_mem_addr;
  logic              r_mem_rd_en;
  logic [S_W-1:0]    r_sample_out;
  logic              r_sample_valid;
  logic [7:0]        r_overrun_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_prime;

  logic w_trigger;
  logic w_overrun_inc;

  // Fetch when the address moved since the last fetch, or once after reset.
  assign w_trigger = (nco_addr != r_last_addr) || r_prime;

  // An address step observed while busy is a missed address; count saturates.
  assign w_overrun_inc = (r_state != ST_IDLE) && (nco_addr != r_addr_q) &&
                         (r_overrun_cnt != 8'hFF);

`ifdef WT_GAIN_EN
  logic [S_W-1:0]           r_raw;
  logic signed [PROD_W-1:0] w_raw_ext;
  logic signed [PROD_W-1:0] w_gain_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic [PROD_W-S_W:0]      w_hi;
  logic [S_W-1:0]           w_scaled;

  // Signed sample times zero-extended gain; the product fits PROD_W exactly.
  assign w_raw_ext  = {{9{r_raw[S_W-1]}}, r_raw};
  assign w_gain_ext = {{(S_W+1){1'b0}}, gain};
  assign w_prod     = w_raw_ext * w_gain_ext;
  assign w_shift    = w_prod >>> 7;
  assign w_hi       = w_shift[PROD_W-1:S_W-1];

  // Clamp to the signed S_W range when the bits above the sign disagree.
  always_comb begin
    w_scaled = w_shift[S_W-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      if (w_shift[PROD_W-1]) begin
        w_scaled = {1'b1, {(S_W-1){1'b0}}};
      end else begin
        w_scaled = {1'b0, {(S_W-1){1'b1}}};
      end
    end
  end
`else
  logic w_unused_gain;
  assign w_unused_gain = ^gain;
`endif

  // Fetch sequencer with all outputs registered.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= ST_IDLE;
      r_mem_addr     <= '0;
      r_mem_rd_en    <= 1'b0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun_cnt  <= 8'd0;
      r_last_addr    <= '0;
      r_addr_q       <= '0;
      r_prime        <= 1'b1;
`ifdef WT_GAIN_EN
      r_raw          <= '0;
`endif
    end else begin
      r_addr_q <= nco_addr;
      if (w_overrun_inc) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_mem_addr  <= {wave_sel, nco_addr};
            r_mem_rd_en <= 1'b1;
            r_last_addr <= nco_addr;
            r_prime     <= 1'b0;
            r_state     <= ST_READ;
          end
        end

        ST_READ: begin
          r_mem_rd_en <= 1'b0;
          r_state     <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
`ifdef WT_GAIN_EN
          r_raw          <= mem_rd_data;
          r_state        <= ST_SCALE;
`else
          r_sample_out   <= mem_rd_data;
          r_sample_valid <= 1'b1;
          r_state        <= ST_PRESENT;
`endif
        end

`ifdef WT_GAIN_EN
        ST_SCALE: begin
          r_sample_out   <= w_scaled;
          r_sample_valid <= 1'b1;
          r_state        <= ST_PRESENT;
        end
`endif

        ST_PRESENT: begin
          if (sample_ready) begin
            r_sample_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_rd_en    = r_mem_rd_en;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign overrun_cnt  = r_overrun_cnt;

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: BRAM model, directed steps and a
// randomized phase checked against an arithmetic reference of the sample path.
module tb_wavetable_reader;

`ifdef WT_GAIN_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        sys_clk;
  logic        sys_rst;
  logic [7:0]  nco_addr;
  logic [1:0]  wave_sel;
  logic [9:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rd_data;
  logic [7:0]  gain;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  overrun_cnt;

  logic [15:0] bram [0:1023];
  int          n_reads;
  int          n_checks;
  int          n_errors;
  int          ov_model;
  logic [15:0] last_sample;

  wavetable_reader dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .nco_addr     (nco_addr),
    .wave_sel     (wave_sel),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .gain         (gain),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun_cnt  (overrun_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Synchronous BRAM: data appears the cycle after an enabled edge.
  always @(posedge sys_clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= bram[mem_addr];
      n_reads     <= n_reads + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference sample path: raw value, or raw*gain/128 (floor) clamped to int16.
  function automatic logic [15:0] exp_sample(input logic [15:0] raw, input logic [7:0] g);
`ifdef WT_GAIN_EN
    int s;
    int p;
    s = int'($signed(raw));
    p = (s * int'(g)) >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
`else
    logic [7:0] unused_g;
    unused_g = g;
    return raw;
`endif
  endfunction

  // Expects the next edge to trigger a fetch of {b,a}; returns with valid just high.
  task automatic fetch_check(input logic [7:0] a, input logic [1:0] b, input logic [7:0] g);
    logic [15:0] e;
    e = exp_sample(bram[{b, a}], g);
    tick();
    chk("rd_en_trigger", 32'(mem_rd_en), 32'd1);
    chk("mem_addr", 32'(mem_addr), 32'({b, a}));
    wave_sel = 2'($urandom);
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (i == 1) chk("rd_en_pulse", 32'(mem_rd_en), 32'd0);
      if (i < LAT - 1) chk("valid_early", 32'(sample_valid), 32'd0);
    end
    chk("valid_rise", 32'(sample_valid), 32'd1);
    chk("sample", 32'(sample_out), 32'(e));
    last_sample = e;
  endtask

  task automatic accept();
    sample_ready = 1'b1;
    tick();
    chk("valid_drop", 32'(sample_valid), 32'd0);
  endtask

`ifdef WT_GAIN_EN
  task automatic gain_case(input logic [7:0] a, input logic [15:0] raw,
                           input logic [7:0] g, input logic [15:0] want);
    bram[{2'd0, a}] = raw;
    gain     = g;
    wave_sel = 2'd0;
    nco_addr = a;
    fetch_check(a, 2'd0, g);
    chk("gain_const", 32'(sample_out), 32'(want));
    accept();
  endtask
`endif

  initial begin
    int r0;
    logic [7:0] prev;
    logic [7:0] a;
    logic [1:0] b;
    logic [7:0] g;
    int stall;

    n_reads  = 0;
    n_checks = 0;
    n_errors = 0;
    ov_model = 0;
    for (int i = 0; i < 1024; i++) bram[i] = 16'($urandom);

    // Reset state
    sys_rst = 1'b1; nco_addr = 8'h00; wave_sel = 2'd1; gain = 8'd128; sample_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    chk("rst_sample", 32'(sample_out), 32'd0);

    // Prime fetch of address 0 in bank 1, then no refetch while address is steady
    r0 = n_reads;
    sys_rst = 1'b0;
    fetch_check(8'h00, 2'd1, gain);
    accept();
    repeat (3) tick();
    chk("prime_single_read", 32'(n_reads - r0), 32'd1);
    chk("idle_no_valid", 32'(sample_valid), 32'd0);

    // Single step 0x10 -> 0x11 with ready tied high
    wave_sel = 2'd0; nco_addr = 8'h10;
    fetch_check(8'h10, 2'd0, gain);
    accept();
    bram[10'h011] = 16'h7FFF;
    r0 = n_reads;
    wave_sel = 2'd0; nco_addr = 8'h11;
    fetch_check(8'h11, 2'd0, gain);
    chk("step_sample_7fff", 32'(sample_out), 32'h7FFF);
    accept();
    repeat (3) tick();
    chk("step_valid_one_cycle", 32'(sample_valid), 32'd0);
    chk("step_single_read", 32'(n_reads - r0), 32'd1);
    chk("step_overrun", 32'(overrun_cnt), 32'(ov_model));

    // Stall: ready low 10 cycles while the address steps 3 times
    sample_ready = 1'b0; wave_sel = 2'd2; nco_addr = 8'h20;
    fetch_check(8'h20, 2'd2, gain);
    r0 = n_reads;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) nco_addr = 8'h21;
      if (c == 4) nco_addr = 8'h22;
      if (c == 7) nco_addr = 8'h23;
      tick();
      chk("stall_valid", 32'(sample_valid), 32'd1);
      chk("stall_hold", 32'(sample_out), 32'(last_sample));
    end
    ov_model += 3;
    chk("stall_overrun", 32'(overrun_cnt), 32'(ov_model));
    wave_sel = 2'd3;
    accept();
    fetch_check(8'h23, 2'd3, gain);
    accept();
    chk("stall_latest_only", 32'(n_reads - r0), 32'd1);

    // Address wrap 0xFF -> 0x00
    wave_sel = 2'd1; nco_addr = 8'hFF;
    fetch_check(8'hFF, 2'd1, gain);
    accept();
    wave_sel = 2'd1; nco_addr = 8'h00;
    fetch_check(8'h00, 2'd1, gain);
    accept();

    // Overrun saturation: 300 address changes while presenting
    sample_ready = 1'b0; wave_sel = 2'd0; nco_addr = 8'h40;
    fetch_check(8'h40, 2'd0, gain);
    for (int c = 0; c < 300; c++) begin
      nco_addr = (c % 2 == 0) ? 8'h41 : 8'h42;
      tick();
    end
    ov_model = (ov_model + 300 > 255) ? 255 : ov_model + 300;
    chk("overrun_sat", 32'(overrun_cnt), 32'(ov_model));
    chk("sat_hold", 32'(sample_out), 32'(last_sample));
    nco_addr = 8'h43;
    tick();
    wave_sel = 2'd2;
    accept();
    fetch_check(8'h43, 2'd2, gain);
    accept();
    chk("overrun_sat_stays", 32'(overrun_cnt), 32'd255);

    // Reset while in READ
    wave_sel = 2'd1; nco_addr = 8'h50;
    tick();
    chk("pre_rst_rd_en", 32'(mem_rd_en), 32'd1);
    sys_rst = 1'b1;
    tick();
    chk("rst_read_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_read_valid", 32'(sample_valid), 32'd0);
    chk("rst_read_overrun", 32'(overrun_cnt), 32'd0);
    ov_model = 0;
    sys_rst = 1'b0; wave_sel = 2'd1;
    fetch_check(8'h50, 2'd1, gain);
    accept();

    // Reset while in PRESENT
    sample_ready = 1'b0; wave_sel = 2'd2; nco_addr = 8'h60;
    fetch_check(8'h60, 2'd2, gain);
    sys_rst = 1'b1;
    tick();
    chk("rst_present_valid", 32'(sample_valid), 32'd0);
    chk("rst_present_sample", 32'(sample_out), 32'd0);
    chk("rst_present_rd_en", 32'(mem_rd_en), 32'd0);
    sys_rst = 1'b0; wave_sel = 2'd3;
    fetch_check(8'h60, 2'd3, gain);
    tick();
    chk("reprime_hold", 32'(sample_valid), 32'd1);
    accept();

`ifdef WT_GAIN_EN
    gain_case(8'h70, 16'h4000, 8'd128, 16'h4000);
    gain_case(8'h71, 16'h7000, 8'd255, 16'h7FFF);
    gain_case(8'h72, 16'h9000, 8'd255, 16'h8000);
    gain_case(8'h73, 16'h1234, 8'd0,   16'h0000);
    gain_case(8'h74, 16'hFFFF, 8'd1,   16'hFFFF);
`endif

    // Randomized transactions with random bank, gain and back-pressure
    prev = nco_addr;
    for (int it = 0; it < 24; it++) begin
      a = 8'($urandom);
      if (a == prev) a = a + 8'd1;
      b = 2'($urandom);
      g = 8'($urandom);
      stall = int'($urandom_range(0, 3));
      gain = g; wave_sel = b; nco_addr = a;
      sample_ready = (stall == 0);
      fetch_check(a, b, g);
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("rand_hold_valid", 32'(sample_valid), 32'd1);
        chk("rand_hold_sample", 32'(sample_out), 32'(last_sample));
      end
      accept();
      prev = a;
    end
    chk("rand_overrun", 32'(overrun_cnt), 32'(ov_model));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
